ddy_dosyasi: RTL and testbench

Machine-mode control/status register (CSR) file of the core. It sits directly downstream of the write-back stage and consumes that stage's CSR write port (`ddy_yaz_*`) plus its retire indication. It also exposes a combinational read port to the execute stage and takes trap-entry and `mret` events from the pipeline. It owns the 64-bit `mcycle`/`minstret` counters and the trap-state CSRs.

---
 rtl/ddy_dosyasi_pkg.sv | 40 ++++
 rtl/ddy_dosyasi_sayac.sv | 25 ++
 rtl/ddy_dosyasi.sv | 115 +++++++++++
 tb/tb_ddy_dosyasi.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddy_dosyasi_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, fixed values and mstatus layout.
package ddy_dosyasi_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_DEGER = 32'h4000_0100;
    localparam logic [31:0] MIE_MASKE  = 32'h0000_0888;
    localparam logic [31:0] ADRES_MASKE = 32'hFFFF_FFFC;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;

    // MPP is hardwired to machine mode; only MIE/MPIE carry state.
    function automatic logic [31:0] mstatus_oku(input logic mie, input logic mpie);
        logic [31:0] d;
        d = '0;
        d[MSTATUS_MPP +: 2] = 2'b11;
        d[MSTATUS_MIE]      = mie;
        d[MSTATUS_MPIE]     = mpie;
        return d;
    endfunction

endpackage

// File: rtl/ddy_dosyasi_sayac.sv
// 64-bit counter with independent half writes; a write in a cycle suppresses that cycle's increment.
module ddy_sayac
    import ddy_dosyasi_pkg::*;
(
    input  logic        clk_g,
    input  logic        rstn_g,
    input  logic        artir_c,
    input  logic        yaz_alt_c,
    input  logic        yaz_ust_c,
    input  logic [31:0] veri_c,
    output logic [63:0] sayac_c
);

    always_ff @(posedge clk_g or negedge rstn_g) begin
        if (!rstn_g) begin
            sayac_c <= '0;
        end else if (yaz_alt_c || yaz_ust_c) begin
            if (yaz_alt_c) sayac_c[31:0]  <= veri_c;
            if (yaz_ust_c) sayac_c[63:32] <= veri_c;
        end else if (artir_c) begin
            sayac_c <= sayac_c + 64'd1;
        end
    end

endmodule

// File: rtl/ddy_dosyasi.sv
// Machine-mode CSR file: trap state, interrupt enables, counters and the execute-stage read port.
module ddy_dosyasi
    import ddy_dosyasi_pkg::*;
#(
    parameter logic [31:0] MTVEC_SIFIRLAMA = 32'h0000_0000,
    parameter logic [31:0] MHARTID         = 32'd0
) (
    input  logic        clk_g,
    input  logic        rstn_g,
    input  logic        ddy_yaz_c,
    input  logic [11:0] ddy_yaz_hedef_c,
    input  logic [31:0] ddy_yaz_veri_c,
    input  logic        emekli_c,
    input  logic [11:0] oku_adres_g,
    output logic [31:0] oku_veri_c,
    output logic        oku_gecerli_c,
    input  logic        istisna_c,
    input  logic [31:0] istisna_neden_c,
    input  logic [31:0] istisna_ps_c,
    input  logic [31:0] istisna_deger_c,
    input  logic        mret_c,
    output logic [31:0] tuzak_ps_c,
    output logic [31:0] donus_ps_c
);

    logic        mie_b, mpie_b;
    logic [31:0] mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r;
    logic [63:0] mcycle, minstret;

    function automatic logic yaz_mi(input logic [11:0] adres);
        return ddy_yaz_c && (ddy_yaz_hedef_c == adres);
    endfunction

    always_ff @(posedge clk_g or negedge rstn_g) begin
        if (!rstn_g) begin
            mie_b      <= 1'b0;
            mpie_b     <= 1'b0;
            mie_r      <= '0;
            mtvec_r    <= MTVEC_SIFIRLAMA;
            mscratch_r <= '0;
            mepc_r     <= '0;
            mcause_r   <= '0;
            mtval_r    <= '0;
        end else begin
            // Trap entry owns mstatus/mepc/mcause/mtval; mret owns only mstatus.
            if (istisna_c) begin
                mepc_r   <= istisna_ps_c;
                mcause_r <= istisna_neden_c;
                mtval_r  <= istisna_deger_c;
                mpie_b   <= mie_b;
                mie_b    <= 1'b0;
            end else begin
                if (mret_c) begin
                    mie_b  <= mpie_b;
                    mpie_b <= 1'b1;
                end else if (yaz_mi(CSR_MSTATUS)) begin
                    mie_b  <= ddy_yaz_veri_c[MSTATUS_MIE];
                    mpie_b <= ddy_yaz_veri_c[MSTATUS_MPIE];
                end
                if (yaz_mi(CSR_MEPC))   mepc_r   <= ddy_yaz_veri_c;
                if (yaz_mi(CSR_MCAUSE)) mcause_r <= ddy_yaz_veri_c;
                if (yaz_mi(CSR_MTVAL))  mtval_r  <= ddy_yaz_veri_c;
            end
            if (yaz_mi(CSR_MIE))      mie_r      <= ddy_yaz_veri_c & MIE_MASKE;
            if (yaz_mi(CSR_MTVEC))    mtvec_r    <= ddy_yaz_veri_c;
            if (yaz_mi(CSR_MSCRATCH)) mscratch_r <= ddy_yaz_veri_c;
        end
    end

    ddy_sayac u_mcycle (
        .clk_g     (clk_g),
        .rstn_g    (rstn_g),
        .artir_c   (1'b1),
        .yaz_alt_c (yaz_mi(CSR_MCYCLE)),
        .yaz_ust_c (yaz_mi(CSR_MCYCLEH)),
        .veri_c    (ddy_yaz_veri_c),
        .sayac_c   (mcycle)
    );

    ddy_sayac u_minstret (
        .clk_g     (clk_g),
        .rstn_g    (rstn_g),
        .artir_c   (emekli_c),
        .yaz_alt_c (yaz_mi(CSR_MINSTRET)),
        .yaz_ust_c (yaz_mi(CSR_MINSTRETH)),
        .veri_c    (ddy_yaz_veri_c),
        .sayac_c   (minstret)
    );

    // Low address bits of mtvec/mepc are stored but never visible.
    assign tuzak_ps_c = mtvec_r & ADRES_MASKE;
    assign donus_ps_c = mepc_r & ADRES_MASKE;

    always_comb begin
        oku_veri_c    = '0;
        oku_gecerli_c = 1'b1;
        case (oku_adres_g)
            CSR_MSTATUS:               oku_veri_c = mstatus_oku(mie_b, mpie_b);
            CSR_MISA:                  oku_veri_c = MISA_DEGER;
            CSR_MIE:                   oku_veri_c = mie_r;
            CSR_MTVEC:                 oku_veri_c = tuzak_ps_c;
            CSR_MSCRATCH:              oku_veri_c = mscratch_r;
            CSR_MEPC:                  oku_veri_c = donus_ps_c;
            CSR_MCAUSE:                oku_veri_c = mcause_r;
            CSR_MTVAL:                 oku_veri_c = mtval_r;
            CSR_MCYCLE, CSR_CYCLE:     oku_veri_c = mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:   oku_veri_c = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET: oku_veri_c = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: oku_veri_c = minstret[63:32];
            CSR_MHARTID:               oku_veri_c = MHARTID;
            default:                   oku_gecerli_c = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ddy_dosyasi.sv
// Randomized bench for the CSR file against a behavioural model of the CSR rules.
module tb_ddy_dosyasi;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0207;
    localparam logic [31:0] HART      = 32'd5;

    logic        clk_g = 1'b0;
    logic        rstn_g;
    logic        ddy_yaz_c;
    logic [11:0] ddy_yaz_hedef_c;
    logic [31:0] ddy_yaz_veri_c;
    logic        emekli_c;
    logic [11:0] oku_adres_g;
    logic [31:0] oku_veri_c;
    logic        oku_gecerli_c;
    logic        istisna_c;
    logic [31:0] istisna_neden_c, istisna_ps_c, istisna_deger_c;
    logic        mret_c;
    logic [31:0] tuzak_ps_c, donus_ps_c;

    int n_chk  = 0;
    int n_pass = 0;

    ddy_dosyasi #(.MTVEC_SIFIRLAMA(MTVEC_RST), .MHARTID(HART)) dut (
        .clk_g(clk_g), .rstn_g(rstn_g),
        .ddy_yaz_c(ddy_yaz_c), .ddy_yaz_hedef_c(ddy_yaz_hedef_c), .ddy_yaz_veri_c(ddy_yaz_veri_c),
        .emekli_c(emekli_c), .oku_adres_g(oku_adres_g), .oku_veri_c(oku_veri_c),
        .oku_gecerli_c(oku_gecerli_c), .istisna_c(istisna_c), .istisna_neden_c(istisna_neden_c),
        .istisna_ps_c(istisna_ps_c), .istisna_deger_c(istisna_deger_c), .mret_c(mret_c),
        .tuzak_ps_c(tuzak_ps_c), .donus_ps_c(donus_ps_c)
    );

    always #5 clk_g = ~clk_g;

    // Reference state: the architectural view of each CSR.
    logic        m_mie, m_mpie;
    logic [31:0] m_mier, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ins;
    logic [31:0] rd_val, rd_donus, rd_tuzak;
    logic        rd_gec;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_mier = 0; m_mtvec = MTVEC_RST & ~32'h3;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
    endtask

    function automatic logic [32:0] ref_read(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7)};
            12'h301: return {1'b1, 32'h4000_0100};
            12'h304: return {1'b1, m_mier};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
            12'hB00, 12'hC00: return {1'b1, m_cyc[31:0]};
            12'hB80, 12'hC80: return {1'b1, m_cyc[63:32]};
            12'hB02, 12'hC02: return {1'b1, m_ins[31:0]};
            12'hB82, 12'hC82: return {1'b1, m_ins[63:32]};
            12'hF14: return {1'b1, HART};
            default: return {1'b0, 32'h0};
        endcase
    endfunction

    task automatic idle();
        ddy_yaz_c = 0; ddy_yaz_hedef_c = 0; ddy_yaz_veri_c = 0; emekli_c = 0;
        oku_adres_g = 0; istisna_c = 0; istisna_neden_c = 0; istisna_ps_c = 0;
        istisna_deger_c = 0; mret_c = 0;
    endtask

    // Called just after a falling edge with inputs already driven; checks, advances the model, moves one cycle.
    task automatic adim();
        logic [32:0] r;
        logic        cw, iw;
        logic        t_mie, t_mpie;
        #1;
        r = ref_read(oku_adres_g);
        rd_val = oku_veri_c; rd_gec = oku_gecerli_c; rd_donus = donus_ps_c; rd_tuzak = tuzak_ps_c;
        chk($sformatf("oku_%h", oku_adres_g), {32'h0, oku_veri_c}, {32'h0, r[31:0]});
        chk("gecerli", {63'h0, oku_gecerli_c}, {63'h0, r[32]});
        chk("tuzak_ps", {32'h0, tuzak_ps_c}, {32'h0, m_mtvec});
        chk("donus_ps", {32'h0, donus_ps_c}, {32'h0, m_mepc});
        cw = 0; iw = 0;
        t_mie = m_mie; t_mpie = m_mpie;
        if (ddy_yaz_c) begin
            case (ddy_yaz_hedef_c)
                12'h300: if (!istisna_c && !mret_c) begin m_mie = ddy_yaz_veri_c[3]; m_mpie = ddy_yaz_veri_c[7]; end
                12'h304: m_mier = ddy_yaz_veri_c & 32'h888;
                12'h305: m_mtvec = ddy_yaz_veri_c & ~32'h3;
                12'h340: m_mscratch = ddy_yaz_veri_c;
                12'h341: if (!istisna_c) m_mepc = ddy_yaz_veri_c & ~32'h3;
                12'h342: if (!istisna_c) m_mcause = ddy_yaz_veri_c;
                12'h343: if (!istisna_c) m_mtval = ddy_yaz_veri_c;
                12'hB00: begin m_cyc[31:0]  = ddy_yaz_veri_c; cw = 1; end
                12'hB80: begin m_cyc[63:32] = ddy_yaz_veri_c; cw = 1; end
                12'hB02: begin m_ins[31:0]  = ddy_yaz_veri_c; iw = 1; end
                12'hB82: begin m_ins[63:32] = ddy_yaz_veri_c; iw = 1; end
                default: ;
            endcase
        end
        if (istisna_c) begin
            m_mepc = istisna_ps_c & ~32'h3; m_mcause = istisna_neden_c; m_mtval = istisna_deger_c;
            m_mpie = t_mie; m_mie = 0;
        end else if (mret_c) begin
            m_mie = t_mpie; m_mpie = 1;
        end
        if (!cw) m_cyc = m_cyc + 1;
        if (!iw && emekli_c) m_ins = m_ins + 1;
        @(posedge clk_g);
        @(negedge clk_g);
    endtask

    task automatic oku(input logic [11:0] a);
        idle(); oku_adres_g = a; adim();
    endtask

    task automatic yaz(input logic [11:0] a, input logic [31:0] d);
        idle(); ddy_yaz_c = 1; ddy_yaz_hedef_c = a; ddy_yaz_veri_c = d; adim();
    endtask

    logic [11:0] adr_tbl [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                  12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h306, 12'hB01};

    function automatic logic [11:0] rnd_adr();
        if ($urandom_range(0, 9) == 0) return 12'($urandom);
        return adr_tbl[$urandom_range(0, 19)];
    endfunction

    logic [31:0] c0;

    initial begin
        idle();
        rstn_g = 0;
        model_reset();
        @(negedge clk_g); @(negedge clk_g);
        #1;
        chk("rst_tuzak", {32'h0, tuzak_ps_c}, 64'h204);
        chk("rst_donus", {32'h0, donus_ps_c}, 64'h0);
        @(negedge clk_g);
        rstn_g = 1;

        // Free-running cycle counter: reads 0 first, 10 after ten edges.
        for (int i = 0; i < 10; i++) oku(12'hB00);
        oku(12'hB00);
        chk("mcycle_10", {32'h0, rd_val}, 64'd10);
        oku(12'h300); chk("mstatus_rst", {32'h0, rd_val}, 64'h1800);
        oku(12'h301); chk("misa", {32'h0, rd_val}, 64'h4000_0100);
        oku(12'hF14); chk("mhartid", {32'h0, rd_val}, 64'd5);

        // 64-bit wrap.
        yaz(12'hB00, 32'hFFFF_FFFF);
        yaz(12'hB80, 32'hFFFF_FFFF);
        oku(12'hB00); chk("mcycle_max", {32'h0, rd_val}, 64'hFFFF_FFFF);
        oku(12'hB00); chk("mcycle_wrap", {32'h0, rd_val}, 64'h0);
        oku(12'hB80); chk("mcycleh_wrap", {32'h0, rd_val}, 64'h0);
        oku(12'hB00); chk("mcycle_after", {32'h0, rd_val}, 64'd2);

        // Counter write beats retire increment.
        idle(); ddy_yaz_c = 1; ddy_yaz_hedef_c = 12'hB02; ddy_yaz_veri_c = 5; emekli_c = 1; adim();
        oku(12'hB02); chk("minstret_wr", {32'h0, rd_val}, 64'd5);

        // Trap entry and mret.
        yaz(12'h300, 32'h8);
        idle(); istisna_c = 1; istisna_neden_c = 32'hB; istisna_ps_c = 32'h80; istisna_deger_c = 32'h1234;
        emekli_c = 1; adim();
        oku(12'h341); chk("mepc_trap", {32'h0, rd_val}, 64'h80);
        oku(12'h342); chk("mcause_trap", {32'h0, rd_val}, 64'hB);
        oku(12'h343); chk("mtval_trap", {32'h0, rd_val}, 64'h1234);
        oku(12'h300); chk("mstatus_trap", {32'h0, rd_val}, 64'h1880);
        idle(); mret_c = 1; adim();
        oku(12'h300); chk("mstatus_mret", {32'h0, rd_val}, 64'h1888);
        chk("donus_mret", {32'h0, rd_donus}, 64'h80);

        // Trap beats a same-cycle mepc write; mtvec low bits are masked.
        idle(); istisna_c = 1; istisna_ps_c = 32'h200; istisna_neden_c = 32'h2;
        ddy_yaz_c = 1; ddy_yaz_hedef_c = 12'h341; ddy_yaz_veri_c = 32'h44; adim();
        oku(12'h341); chk("mepc_pri", {32'h0, rd_val}, 64'h200);
        yaz(12'h305, 32'h103);
        oku(12'h0); chk("tuzak_103", {32'h0, rd_tuzak}, 64'h100);

        // Read-only alias and unimplemented address.
        oku(12'hC00); c0 = rd_val;
        idle(); ddy_yaz_c = 1; ddy_yaz_hedef_c = 12'hC00; ddy_yaz_veri_c = 32'h0; oku_adres_g = 12'hC00; adim();
        oku(12'hC00); chk("cycle_ro", {32'h0, rd_val}, {32'h0, c0 + 32'd2});
        oku(12'h7C0);
        chk("bos_gecerli", {63'h0, rd_gec}, 64'h0);
        chk("bos_veri", {32'h0, rd_val}, 64'h0);

        // Randomized traffic with a reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rstn_g = 0; idle(); oku_adres_g = 12'hB00;
                #1;
                chk("arst_mcycle", {32'h0, oku_veri_c}, 64'h0);
                chk("arst_tuzak", {32'h0, tuzak_ps_c}, 64'h204);
                model_reset();
                @(negedge clk_g);
                rstn_g = 1;
            end
            idle();
            ddy_yaz_c = ($urandom_range(0, 2) == 0);
            ddy_yaz_hedef_c = rnd_adr();
            ddy_yaz_veri_c = $urandom;
            emekli_c = $urandom_range(0, 1);
            oku_adres_g = rnd_adr();
            istisna_c = ($urandom_range(0, 7) == 0);
            istisna_neden_c = $urandom; istisna_ps_c = $urandom; istisna_deger_c = $urandom;
            mret_c = ($urandom_range(0, 7) == 0);
            adim();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
